// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD sequencer: FSM encodings,
// power-on command table, io_lcd bit layout and the execution-time classifier.
package lcd_pkg;

   typedef logic [2:0] lcd_state_t;

   localparam lcd_state_t PWR_WAIT = 3'd0;
   localparam lcd_state_t SETUP    = 3'd1;
   localparam lcd_state_t EN_HI    = 3'd2;
   localparam lcd_state_t HOLD     = 3'd3;
   localparam lcd_state_t EXEC     = 3'd4;
   localparam lcd_state_t IDLE     = 3'd5;

   localparam int INIT_LEN = 5;

   // Function set 8-bit/2-line (twice), display on, clear, entry mode increment.
   localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   localparam int LCD_ON_BIT   = 31;
   localparam int LCD_EN_BIT   = 10;
   localparam int LCD_RW_BIT   = 9;
   localparam int LCD_RS_BIT   = 8;
   localparam int LCD_DATA_LSB = 0;

   // Clear and home (and the 0x03 alias of home) need the long execution wait.
   function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
      logic [1:0] slow_bits;
      slow_bits = CMD_CLEAR[1:0] | CMD_HOME[1:0];
      return !rs && (data[7:2] == 6'd0) && ((data[1:0] & slow_bits) != 2'b00);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that parks at zero and flags it; also used by the
// button debouncer, so it carries no LCD-specific knowledge.
module lcd_timer #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: power-on init, then LSU command/data bytes, each
// driven with setup, enable pulse, hold and execution timing onto io_lcd.
module lcd_ctrl #(
   parameter int T_PWR  = 750000,
   parameter int T_SU   = 2,
   parameter int T_EN   = 12,
   parameter int T_HOLD = 2,
   parameter int T_EXEC = 2000,
   parameter int T_CLR  = 82000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_vld,
   input  logic        wr_rs,
   input  logic [7:0]  wr_data,
   output logic        wr_rdy,
   output logic        busy,
   output logic        init_done,
   output logic [31:0] io_lcd
);

   import lcd_pkg::*;

   localparam int T_MAX = max_of(max_of(max_of(T_PWR, T_SU), max_of(T_EN, T_HOLD)),
                                 max_of(T_EXEC, T_CLR));
   localparam int CNT_W = $clog2(T_MAX) + 1;

   localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(T_PWR - 1);
   localparam logic [CNT_W-1:0] LD_SU   = CNT_W'(T_SU - 1);
   localparam logic [CNT_W-1:0] LD_EN   = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_EXEC = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LD_CLR  = CNT_W'(T_CLR - 1);
   localparam logic [2:0]       IDX_LAST = 3'(INIT_LEN - 1);

   lcd_state_t       state;
   lcd_state_t       state_next;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;
   logic [2:0]       init_idx;
   logic [2:0]       init_idx_next;
   logic             set_init_done;
   logic             next_rs;
   logic [7:0]       next_data;
   logic             lcd_on;
   logic             lcd_en;
   logic             lcd_rw;
   logic             lcd_rs;
   logic [7:0]       lcd_data;

   lcd_timer #(
      .WIDTH     (CNT_W),
      .RESET_VAL (LD_PWR)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // The byte to send is latched on the same edge that enters SETUP, so the
   // LOAD step costs no cycle and RS/DATA are stable for the whole setup time.
   always_comb begin
      state_next    = state;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      init_idx_next = init_idx;
      set_init_done = 1'b0;
      next_rs       = lcd_rs;
      next_data     = lcd_data;
      case (state)
         PWR_WAIT: begin
            if (tmr_done) begin
               state_next    = SETUP;
               tmr_load      = 1'b1;
               tmr_val       = LD_SU;
               init_idx_next = 3'd0;
               next_rs       = 1'b0;
               next_data     = INIT_SEQ[0];
            end
         end
         SETUP: begin
            if (tmr_done) begin
               state_next = EN_HI;
               tmr_load   = 1'b1;
               tmr_val    = LD_EN;
            end
         end
         EN_HI: begin
            if (tmr_done) begin
               state_next = HOLD;
               tmr_load   = 1'b1;
               tmr_val    = LD_HOLD;
            end
         end
         HOLD: begin
            if (tmr_done) begin
               state_next = EXEC;
               tmr_load   = 1'b1;
               tmr_val    = is_long_exec(lcd_rs, lcd_data) ? LD_CLR : LD_EXEC;
            end
         end
         EXEC: begin
            if (tmr_done) begin
               if (init_done) begin
                  state_next = IDLE;
               end else if (init_idx == IDX_LAST) begin
                  state_next    = IDLE;
                  set_init_done = 1'b1;
               end else begin
                  state_next    = SETUP;
                  tmr_load      = 1'b1;
                  tmr_val       = LD_SU;
                  init_idx_next = init_idx + 3'd1;
                  next_rs       = 1'b0;
                  next_data     = INIT_SEQ[init_idx_next];
               end
            end
         end
         IDLE: begin
            if (wr_vld) begin
               state_next = SETUP;
               tmr_load   = 1'b1;
               tmr_val    = LD_SU;
               next_rs    = wr_rs;
               next_data  = wr_data;
            end
         end
         default: begin
            state_next = PWR_WAIT;
            tmr_load   = 1'b1;
            tmr_val    = LD_PWR;
         end
      endcase
   end

   // EN is a register decoded from the next state, so it cannot glitch between bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PWR_WAIT;
         init_idx  <= 3'd0;
         init_done <= 1'b0;
         lcd_on    <= 1'b0;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
      end else begin
         state    <= state_next;
         init_idx <= init_idx_next;
         if (set_init_done) begin
            init_done <= 1'b1;
         end
         lcd_on   <= 1'b1;
         lcd_en   <= (state_next == EN_HI);
         lcd_rs   <= next_rs;
         lcd_data <= next_data;
      end
   end

   assign lcd_rw = 1'b0;
   assign wr_rdy = (state == IDLE);
   assign busy   = (state != IDLE);

   always_comb begin
      io_lcd                         = '0;
      io_lcd[LCD_ON_BIT]             = lcd_on;
      io_lcd[LCD_EN_BIT]             = lcd_en;
      io_lcd[LCD_RW_BIT]             = lcd_rw;
      io_lcd[LCD_RS_BIT]             = lcd_rs;
      io_lcd[LCD_DATA_LSB +: 8]      = lcd_data;
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing; expected cycle counts and
// EN pulse trains are worked out by hand from the sequencer timing.
module tb_lcd_ctrl;

   localparam int T_PWR  = 10;
   localparam int T_SU   = 2;
   localparam int T_EN   = 3;
   localparam int T_HOLD = 2;
   localparam int T_EXEC = 5;
   localparam int T_CLR  = 20;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_vld = 1'b0;
   logic        wr_rs  = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_rdy;
   logic        busy;
   logic        init_done;
   logic [31:0] io_lcd;

   int n_checks = 0;
   int n_fail   = 0;

   int         pcount;
   logic [7:0] pdata [16];
   logic       prs [16];
   int         pwidth [16];
   logic       en_prev;
   logic       on_after_first_edge;

   logic [7:0] exp_init [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   always #5 clk = ~clk;

   lcd_ctrl #(
      .T_PWR  (T_PWR),
      .T_SU   (T_SU),
      .T_EN   (T_EN),
      .T_HOLD (T_HOLD),
      .T_EXEC (T_EXEC),
      .T_CLR  (T_CLR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_vld    (wr_vld),
      .wr_rs     (wr_rs),
      .wr_data   (wr_data),
      .wr_rdy    (wr_rdy),
      .busy      (busy),
      .init_done (init_done),
      .io_lcd    (io_lcd)
   );

   // Advance to the next falling edge and log any EN pulse seen on the pins.
   task automatic step();
      @(negedge clk);
      if (io_lcd[10] && !en_prev) begin
         if (pcount < 16) begin
            pdata[pcount]  = io_lcd[7:0];
            prs[pcount]    = io_lcd[8];
            pwidth[pcount] = 1;
         end
         pcount++;
      end else if (io_lcd[10] && pcount > 0 && pcount <= 16) begin
         pwidth[pcount-1]++;
      end
      en_prev = io_lcd[10];
   endtask

   task automatic clear_capture();
      pcount  = 0;
      en_prev = io_lcd[10];
      for (int i = 0; i < 16; i++) begin
         pdata[i]  = 8'h00;
         prs[i]    = 1'b0;
         pwidth[i] = 0;
      end
   endtask

   task automatic release_and_wait(output int rdy_cycle);
      rdy_cycle = -1;
      clear_capture();
      rst_n = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (k == 1) on_after_first_edge = io_lcd[31];
         if (wr_rdy) begin
            rdy_cycle = k;
            return;
         end
      end
   endtask

   task automatic wait_ready(output int gap);
      gap = -1;
      for (int k = 1; k <= 200; k++) begin
         step();
         if (wr_rdy) begin
            gap = k;
            return;
         end
      end
   endtask

   task automatic do_write(input logic rs, input logic [7:0] d, output int gap);
      int w;
      gap = -1;
      w = 0;
      while (!wr_rdy && w < 200) begin
         step();
         w++;
      end
      if (!wr_rdy) return;
      wr_vld  = 1'b1;
      wr_rs   = rs;
      wr_data = d;
      step();
      wr_vld = 1'b0;
      wait_ready(gap);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      wr_vld = 1'b0;
      step();
      step();
      n_checks++; if (io_lcd !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_io_lcd: got %h expected %h", io_lcd, 32'h0); end
      n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_rdy: got %b expected 0", wr_rdy); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
      n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
   endtask

   task automatic test_init();
      int c;
      release_and_wait(c);
      n_checks++; if (on_after_first_edge !== 1'b1) begin n_fail++; $display("[TB] FAIL init_lcd_on: got %b expected 1", on_after_first_edge); end
      n_checks++; if (c !== 85) begin n_fail++; $display("[TB] FAIL init_ready_cycle: got %0d expected 85", c); end
      n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("[TB] FAIL init_done: got %b expected 1", init_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL init_busy: got %b expected 0", busy); end
      n_checks++; if (io_lcd[9] !== 1'b0) begin n_fail++; $display("[TB] FAIL init_rw: got %b expected 0", io_lcd[9]); end
      n_checks++; if (pcount !== 5) begin n_fail++; $display("[TB] FAIL init_pulse_count: got %0d expected 5", pcount); end
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (pdata[i] !== exp_init[i]) begin n_fail++; $display("[TB] FAIL init_data[%0d]: got %h expected %h", i, pdata[i], exp_init[i]); end
         n_checks++; if (prs[i] !== 1'b0) begin n_fail++; $display("[TB] FAIL init_rs[%0d]: got %b expected 0", i, prs[i]); end
         n_checks++; if (pwidth[i] !== 3) begin n_fail++; $display("[TB] FAIL init_width[%0d]: got %0d expected 3", i, pwidth[i]); end
      end
   endtask

   task automatic test_single_write();
      logic exp_en;
      n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_pre_rdy: got %b expected 1", wr_rdy); end
      wr_vld  = 1'b1;
      wr_rs   = 1'b1;
      wr_data = 8'h41;
      for (int k = 0; k <= 12; k++) begin
         step();
         if (k == 0) wr_vld = 1'b0;
         exp_en = (k >= 2 && k <= 4);
         if (k < 12) begin
            n_checks++; if (io_lcd[10] !== exp_en) begin n_fail++; $display("[TB] FAIL single_en k=%0d: got %b expected %b", k, io_lcd[10], exp_en); end
            n_checks++; if (io_lcd[8:0] !== 9'h141) begin n_fail++; $display("[TB] FAIL single_rs_data k=%0d: got %h expected 141", k, io_lcd[8:0]); end
            n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_rdy_low k=%0d: got %b expected 0", k, wr_rdy); end
         end else begin
            n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rdy_12: got %b expected 1", wr_rdy); end
            n_checks++; if (io_lcd[10:0] !== 11'h141) begin n_fail++; $display("[TB] FAIL single_idle_hold: got %h expected 141", io_lcd[10:0]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int g1;
      int g2;
      wr_vld  = 1'b1;
      wr_rs   = 1'b0;
      wr_data = 8'h01;
      step();
      n_checks++; if (io_lcd[8:0] !== 9'h001) begin n_fail++; $display("[TB] FAIL b2b_first_data: got %h expected 001", io_lcd[8:0]); end
      wait_ready(g1);
      wr_data = 8'h80;
      step();
      n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_one_cycle: got %b expected 0", wr_rdy); end
      n_checks++; if (io_lcd[8:0] !== 9'h080) begin n_fail++; $display("[TB] FAIL b2b_second_data: got %h expected 080", io_lcd[8:0]); end
      wait_ready(g2);
      wr_vld = 1'b0;
      n_checks++; if (g1 !== 27) begin n_fail++; $display("[TB] FAIL b2b_gap_clear: got %0d expected 27", g1); end
      n_checks++; if (g2 !== 12) begin n_fail++; $display("[TB] FAIL b2b_gap_normal: got %0d expected 12", g2); end
   endtask

   task automatic test_long_exec_boundary();
      int g;
      do_write(1'b0, 8'h03, g);
      n_checks++; if (g !== 27) begin n_fail++; $display("[TB] FAIL boundary_03: got %0d expected 27", g); end
      do_write(1'b0, 8'h04, g);
      n_checks++; if (g !== 12) begin n_fail++; $display("[TB] FAIL boundary_04: got %0d expected 12", g); end
      do_write(1'b1, 8'h01, g);
      n_checks++; if (g !== 12) begin n_fail++; $display("[TB] FAIL boundary_data_01: got %0d expected 12", g); end
   endtask

   task automatic test_reset_mid_write();
      int c;
      wr_vld  = 1'b1;
      wr_rs   = 1'b1;
      wr_data = 8'h41;
      step();
      wr_vld = 1'b0;
      step();
      step();
      n_checks++; if (io_lcd[10] !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_en_high: got %b expected 1", io_lcd[10]); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (io_lcd !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_io_lcd: got %h expected %h", io_lcd, 32'h0); end
      n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_wr_rdy: got %b expected 0", wr_rdy); end
      n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_init_done: got %b expected 0", init_done); end
      step();
      release_and_wait(c);
      n_checks++; if (c !== 85) begin n_fail++; $display("[TB] FAIL midrst_reinit_cycle: got %0d expected 85", c); end
      n_checks++; if (pcount !== 5) begin n_fail++; $display("[TB] FAIL midrst_pulse_count: got %0d expected 5", pcount); end
      n_checks++; if (pdata[3] !== 8'h01) begin n_fail++; $display("[TB] FAIL midrst_clear_byte: got %h expected 01", pdata[3]); end
   endtask

   task automatic test_vld_during_init();
      int   first;
      int   second;
      logic done_at_first;
      logic rdy_after_accept;
      first            = -1;
      second           = -1;
      done_at_first    = 1'b0;
      rdy_after_accept = 1'b1;
      rst_n   = 1'b0;
      wr_vld  = 1'b1;
      wr_rs   = 1'b1;
      wr_data = 8'h55;
      step();
      clear_capture();
      rst_n = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (first < 0) begin
            if (wr_rdy) begin
               first         = k;
               done_at_first = init_done;
            end
         end else if (k == first + 1) begin
            wr_vld           = 1'b0;
            rdy_after_accept = wr_rdy;
         end else if (wr_rdy) begin
            second = k;
            break;
         end
      end
      wr_vld = 1'b0;
      n_checks++; if (first !== 85) begin n_fail++; $display("[TB] FAIL vldinit_first_rdy: got %0d expected 85", first); end
      n_checks++; if (done_at_first !== 1'b1) begin n_fail++; $display("[TB] FAIL vldinit_done_at_rdy: got %b expected 1", done_at_first); end
      n_checks++; if (rdy_after_accept !== 1'b0) begin n_fail++; $display("[TB] FAIL vldinit_accept: got %b expected 0", rdy_after_accept); end
      n_checks++; if (second !== 98) begin n_fail++; $display("[TB] FAIL vldinit_second_rdy: got %0d expected 98", second); end
      n_checks++; if (pcount !== 6) begin n_fail++; $display("[TB] FAIL vldinit_pulse_count: got %0d expected 6", pcount); end
      n_checks++; if (pdata[5] !== 8'h55) begin n_fail++; $display("[TB] FAIL vldinit_data: got %h expected 55", pdata[5]); end
      n_checks++; if (prs[5] !== 1'b1) begin n_fail++; $display("[TB] FAIL vldinit_rs: got %b expected 1", prs[5]); end
      n_checks++; if (pdata[4] !== 8'h06) begin n_fail++; $display("[TB] FAIL vldinit_last_init: got %h expected 06", pdata[4]); end
   endtask

   initial begin
      clear_capture();
      on_after_first_edge = 1'b0;
      $display("[TB] lcd_ctrl directed test start");
      test_reset();
      test_init();
      test_single_write();
      test_back_to_back();
      test_long_exec_boundary();
      test_reset_mid_write();
      test_vld_during_init();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
